// File: rtl/fifo_level_pkg.sv
// fifo_level_pkg
// Shared definitions for the fifo_level_buffer slice:
//   depth_of()    - entry count for a given address width
//   level_t       - occupancy type for the default configuration (DEPTH_LENGTH = 4)
//   RST_*         - reset/clear values of the status and error flags
package fifo_level_pkg;

  localparam int unsigned DEF_DEPTH_LENGTH = 4;

  typedef logic [DEF_DEPTH_LENGTH:0] level_t;

  localparam logic RST_EMPTY  = 1'b1;
  localparam logic RST_FULL   = 1'b0;
  localparam logic RST_AEMPTY = 1'b1;
  localparam logic RST_AFULL  = 1'b0;
  localparam logic RST_ERR    = 1'b0;

  function automatic int unsigned depth_of(input int unsigned dl);
    return 32'd1 << dl;
  endfunction

endpackage

// File: rtl/fifo_level_ram.sv
// fifo_level_ram
// 1-write / 1-read storage array (depth x LENGTH) for fifo_level_buffer.
// Ports:
//   clk      - system clock, rising edge
//   clr_i    - synchronous clear of the registered read data (not the array)
//   we_i     - write enable; wdata_i stored at waddr_i
//   re_i     - read enable; mem[raddr_i] captured into the read register
//   rd_data_o- registered read data (FWFT=0) or combinational mem[raddr_i] (FWFT=1)
module fifo_level_ram
  import fifo_level_pkg::*;
#(
  parameter int unsigned LENGTH       = 68,
  parameter int unsigned DEPTH_LENGTH = 4,
  parameter bit          FWFT         = 1'b0
) (
  input  logic                    clk,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [DEPTH_LENGTH-1:0] waddr_i,
  input  logic [LENGTH-1:0]       wdata_i,
  input  logic                    re_i,
  input  logic [DEPTH_LENGTH-1:0] raddr_i,
  output logic [LENGTH-1:0]       rd_data_o
);

  localparam int unsigned DEPTH = depth_of(DEPTH_LENGTH);

  logic [LENGTH-1:0] mem_q [DEPTH];
  logic [LENGTH-1:0] rdata_q;

  // Array contents are never reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rd_data_o = FWFT ? mem_q[raddr_i] : rdata_q;

endmodule

// File: rtl/fifo_level_buffer.sv
// fifo_level_buffer
// Synchronous FIFO with occupancy count, programmable almost-full/almost-empty
// flags and sticky overflow/underflow errors. Sits between the decimation filter
// (writer) and the readout/serialiser (reader).
// Optional build macro FIFO_FWFT_EN: first-word fall-through read port
// (o_data shows the head whenever !empty); otherwise o_data is registered and
// shows the popped word one cycle after the read edge.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   i_data, write     - write data / request
//   read              - read request
//   clear             - synchronous flush (same effect as reset)
//   o_data            - read data
//   full, empty       - level == depth / level == 0
//   almost_full       - level >= AFULL_THRESH
//   almost_empty      - level <= AEMPTY_THRESH
//   level             - occupancy 0..depth
//   full_error        - sticky: write while full without read
//   empty_error       - sticky: read while empty
module fifo_level_buffer
  import fifo_level_pkg::*;
#(
  parameter int unsigned LENGTH        = 68,
  parameter int unsigned DEPTH_LENGTH  = 4,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LENGTH-1:0]       i_data,
  input  logic                    write,
  input  logic                    read,
  input  logic                    clear,
  output logic [LENGTH-1:0]       o_data,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [DEPTH_LENGTH:0]   level,
  output logic                    full_error,
  output logic                    empty_error
);

  localparam int unsigned LW = DEPTH_LENGTH + 1;
  localparam logic [DEPTH_LENGTH:0] DEPTH_LVL = LW'(depth_of(DEPTH_LENGTH));
  localparam logic [DEPTH_LENGTH:0] AF_LVL    = LW'(AFULL_THRESH);
  localparam logic [DEPTH_LENGTH:0] AE_LVL    = LW'(AEMPTY_THRESH);

`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic [DEPTH_LENGTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LENGTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LENGTH:0]   level_q, level_d;
  logic full_q, full_d, empty_q, empty_d;
  logic afull_q, afull_d, aempty_q, aempty_d;
  logic ferr_q, ferr_d, eerr_q, eerr_d;
  logic wr_acc, rd_acc, flush;
  logic [LENGTH-1:0] ram_rd;

  // reset and clear both discard any access in that cycle
  assign flush  = reset | clear;
  // a read on a full FIFO frees the slot the write lands in
  assign wr_acc = write & (~full_q | read) & ~flush;
  assign rd_acc = read & ~empty_q & ~flush;

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + DEPTH_LENGTH'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + DEPTH_LENGTH'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d   = (level_d == DEPTH_LVL);
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= AF_LVL);
    aempty_d = (level_d <= AE_LVL);
    ferr_d   = ferr_q | (write & full_q & ~read);
    eerr_d   = eerr_q | (read & empty_q);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= RST_FULL;
      empty_q  <= RST_EMPTY;
      afull_q  <= RST_AFULL;
      aempty_q <= RST_AEMPTY;
      ferr_q   <= RST_ERR;
      eerr_q   <= RST_ERR;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ferr_q   <= ferr_d;
      eerr_q   <= eerr_d;
    end
  end

  fifo_level_ram #(
    .LENGTH       (LENGTH),
    .DEPTH_LENGTH (DEPTH_LENGTH),
    .FWFT         (FWFT)
  ) u_ram (
    .clk       (clk),
    .clr_i     (flush),
    .we_i      (wr_acc),
    .waddr_i   (wr_ptr_q),
    .wdata_i   (i_data),
    .re_i      (rd_acc),
    .raddr_i   (rd_ptr_q),
    .rd_data_o (ram_rd)
  );

`ifdef FIFO_FWFT_EN
  // the array head is stale while empty, so present zero until a word lands
  assign o_data = empty_q ? '0 : ram_rd;
`else
  assign o_data = ram_rd;
`endif

  assign level        = level_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign full_error   = ferr_q;
  assign empty_error  = eerr_q;

endmodule

// File: tb/tb_fifo_level_buffer.sv
// tb_fifo_level_buffer
// Directed bench for fifo_level_buffer (LENGTH=68, depth 16, AF=12, AE=2).
// Default build exercises standard registered-read mode; with FIFO_FWFT_EN
// defined it exercises the fall-through read port.
module tb_fifo_level_buffer;
  import fifo_level_pkg::*;

  logic        clk = 1'b0;
  logic        reset, write, read, clear;
  logic [67:0] i_data, o_data;
  logic        full, empty, almost_full, almost_empty, full_error, empty_error;
  logic [4:0]  level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_level_buffer #(
    .LENGTH(68), .DEPTH_LENGTH(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .write(write), .read(read),
    .clear(clear), .o_data(o_data), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .full_error(full_error), .empty_error(empty_error)
  );

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input level_t lvl, input logic e, input logic f,
                        input logic ae, input logic af, input logic fe, input logic ee);
    chk({tag, ".level"}, 68'(level), 68'(lvl));
    chk({tag, ".empty"}, 68'(empty), 68'(e));
    chk({tag, ".full"}, 68'(full), 68'(f));
    chk({tag, ".aempty"}, 68'(almost_empty), 68'(ae));
    chk({tag, ".afull"}, 68'(almost_full), 68'(af));
    chk({tag, ".ferr"}, 68'(full_error), 68'(fe));
    chk({tag, ".eerr"}, 68'(empty_error), 68'(ee));
  endtask

  // drive one cycle of stimulus, then settle just after the rising edge
  task automatic cyc(input logic rs, input logic c, input logic w, input logic r,
                     input logic [67:0] d);
    reset = rs; clear = c; write = w; read = r; i_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; write = 1'b0; read = 1'b0; i_data = '0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst.odata", o_data, 68'h0);
    chk_st("rst", 5'd0, 1, 0, 1, 0, 0, 0);

`ifdef FIFO_FWFT_EN
    cyc(0, 0, 1, 0, 68'h99);
    chk("fwft.odata99", o_data, 68'h99);
    chk_st("fwft.w1", 5'd1, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 68'hA1);
    chk("fwft.head", o_data, 68'h99);
    cyc(0, 0, 0, 1, 0);
    chk("fwft.next", o_data, 68'hA1);
    chk_st("fwft.r1", 5'd1, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 68'hB2);
    chk("fwft.rw", o_data, 68'hB2);
    cyc(0, 0, 0, 1, 0);
    chk_st("fwft.drained", 5'd0, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 68'hC3);
    chk_st("fwft.rw_empty", 5'd1, 0, 0, 1, 0, 0, 1);
    chk("fwft.rw_empty.odata", o_data, 68'hC3);
`else
    // fill with 1..16
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 0, 1, 0, 68'(i));
      chk_st($sformatf("fill%0d", i), 5'(i), 0, i == 16, i <= 2, i >= 12, 0, 0);
    end

    // simultaneous read+write at full: pops 1, stores 0x55 at the tail
    cyc(0, 0, 1, 1, 68'h55);
    chk("rw_full.odata", o_data, 68'h1);
    chk_st("rw_full", 5'd16, 0, 1, 0, 1, 0, 0);

    // overflow: 0xAA dropped
    cyc(0, 0, 1, 0, 68'hAA);
    chk("ovf.odata_hold", o_data, 68'h1);
    chk_st("ovf", 5'd16, 0, 1, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("ovf.sticky", 68'(full_error), 68'h1);

    // drain: 2..16 then 0x55
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 0, 1, 0);
      chk($sformatf("drain%0d.odata", k), o_data, (k < 15) ? 68'(k + 2) : 68'h55);
      chk_st($sformatf("drain%0d", k), 5'(15 - k), k == 15, 0, (15 - k) <= 2, (15 - k) >= 12, 1, 0);
    end

    // underflow
    cyc(0, 0, 0, 1, 0);
    chk("unf.odata_hold", o_data, 68'h55);
    chk_st("unf", 5'd0, 1, 0, 1, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    chk("unf.sticky", 68'(empty_error), 68'h1);
    cyc(0, 1, 1, 1, 68'hEE);
    chk("clr.odata", o_data, 68'h0);
    chk_st("clr", 5'd0, 1, 0, 1, 0, 0, 0);

    // read+write while empty: read rejected
    cyc(0, 0, 1, 1, 68'h77);
    chk("rw_empty.odata", o_data, 68'h0);
    chk_st("rw_empty", 5'd1, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    chk("rw_empty.pop", o_data, 68'h77);
    cyc(0, 1, 0, 0, 0);
    chk_st("clr2", 5'd0, 1, 0, 1, 0, 0, 0);

    // wrap-around with level held at 3
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 68'(100 + i));
    for (int k = 0; k < 40; k++) begin
      cyc(0, 0, 1, 1, 68'(103 + k));
      chk($sformatf("wrap%0d.odata", k), o_data, 68'(100 + k));
      chk($sformatf("wrap%0d.level", k), 68'(level), 68'd3);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 1, 0);
      chk($sformatf("wrapdrain%0d", k), o_data, 68'(140 + k));
    end
    chk_st("wrap.end", 5'd0, 1, 0, 1, 0, 0, 0);

    // reset mid-operation at level 7 with a write pending
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 68'(68'h200 + i));
    cyc(0, 0, 0, 1, 0);
    chk("pre_rst.odata", o_data, 68'h200);
    chk_st("pre_rst", 5'd7, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 68'hDEAD);
    chk("mid_rst.odata", o_data, 68'h0);
    chk_st("mid_rst", 5'd0, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk_st("post_rst", 5'd0, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 68'h300);
    cyc(0, 0, 0, 1, 0);
    chk("post_rst.pop", o_data, 68'h300);
    chk_st("post_rst.end", 5'd0, 1, 0, 1, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
